// File: rtl/arm_link_responder.sv
`default_nettype none
// ============================================================================
//  Module      : arm_link_responder
//  Description : FPGA-side endpoint of the ARM<->FPGA command/data link.
//                Decodes commands, loads operand registers, launches the
//                exponentiation / Montgomery cores, captures and returns the
//                result, and reports completion via the done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module arm_link_responder #(
    parameter int DW    = 1024,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      arm_to_fpga_cmd,
    input  logic             arm_to_fpga_cmd_valid,
    output logic             fpga_to_arm_done,
    input  logic             fpga_to_arm_done_read,
    input  logic             arm_to_fpga_data_valid,
    output logic             arm_to_fpga_data_ready,
    input  logic [DW-1:0]    arm_to_fpga_data,
    output logic             fpga_to_arm_data_valid,
    input  logic             fpga_to_arm_data_ready,
    output logic [DW-1:0]    fpga_to_arm_data,
    output logic             core_start_exp,
    output logic             core_start_mont,
    input  logic             core_done,
    input  logic [DW-1:0]    core_result,
    output logic [DW-1:0]    reg_exp,
    output logic [DW-1:0]    reg_ab,
    output logic [DW-1:0]    reg_m,
    output logic [CNT_W-1:0] compute_cycles,
    output logic [3:0]       leds
);

    localparam logic [31:0] C_CMD_READ_EXP     = 32'd0;
    localparam logic [31:0] C_CMD_READ_A_B     = 32'd1;
    localparam logic [31:0] C_CMD_READ_M       = 32'd2;
    localparam logic [31:0] C_CMD_COMPUTE_EXP  = 32'd3;
    localparam logic [31:0] C_CMD_COMPUTE_MONT = 32'd4;
    localparam logic [31:0] C_CMD_WRITE        = 32'd5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX      = 3'd1,
        S_COMPUTE = 3'd2,
        S_TX      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_cmd_q;
    logic              r_first;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_cycles;
    logic [DW-1:0]     r_result;
    logic [DW-1:0]     r_exp;
    logic [DW-1:0]     r_ab;
    logic [DW-1:0]     r_m;
    logic              w_rx_fire;
    logic              w_cmd_accept;

    assign w_cmd_accept = (r_state == S_IDLE) && arm_to_fpga_cmd_valid;
    assign w_rx_fire    = (r_state == S_RX) && arm_to_fpga_data_valid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_state_next           = r_state;
        arm_to_fpga_data_ready = 1'b0;
        fpga_to_arm_data_valid = 1'b0;
        fpga_to_arm_done       = 1'b0;
        core_start_exp         = 1'b0;
        core_start_mont        = 1'b0;
        leds                   = 4'b0001;
        case (r_state)
            S_IDLE: begin
                leds = 4'b0001;
                if (arm_to_fpga_cmd_valid) begin
                    case (arm_to_fpga_cmd)
                        C_CMD_READ_EXP, C_CMD_READ_A_B, C_CMD_READ_M:
                            w_state_next = S_RX;
                        C_CMD_COMPUTE_EXP, C_CMD_COMPUTE_MONT:
                            w_state_next = S_COMPUTE;
                        C_CMD_WRITE:
                            w_state_next = S_TX;
                        default:
                            w_state_next = S_DONE;
                    endcase
                end
            end
            S_RX: begin
                leds                   = 4'b0010;
                arm_to_fpga_data_ready = 1'b1;
                if (arm_to_fpga_data_valid) w_state_next = S_DONE;
            end
            S_COMPUTE: begin
                leds            = 4'b0100;
                // r_first marks the entry cycle so the start strobe is one cycle wide
                core_start_exp  = r_first && (r_cmd_q == C_CMD_COMPUTE_EXP);
                core_start_mont = r_first && (r_cmd_q == C_CMD_COMPUTE_MONT);
                if (core_done) w_state_next = S_DONE;
            end
            S_TX: begin
                leds                   = 4'b1000;
                fpga_to_arm_data_valid = 1'b1;
                if (fpga_to_arm_data_ready) w_state_next = S_DONE;
            end
            S_DONE: begin
                leds             = 4'b1111;
                fpga_to_arm_done = 1'b1;
                if (fpga_to_arm_done_read) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command latch and compute-entry marker
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_q <= '0;
            r_first <= 1'b0;
        end else begin
            if (w_cmd_accept) r_cmd_q <= arm_to_fpga_cmd;
            r_first <= w_cmd_accept && (w_state_next == S_COMPUTE);
        end
    end

    // Compute-cycle counter: zero on the entry cycle, saturating upward
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state != S_COMPUTE) begin
            r_cnt <= '0;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Result capture on core completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_cycles <= '0;
        end else if ((r_state == S_COMPUTE) && core_done) begin
            r_result <= core_result;
            r_cycles <= r_cnt;
        end
    end

    // Operand registers: one word per READ command, selected by the latched code
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exp <= '0;
            r_ab  <= '0;
            r_m   <= '0;
        end else if (w_rx_fire) begin
            if (r_cmd_q == C_CMD_READ_EXP) r_exp <= arm_to_fpga_data;
            if (r_cmd_q == C_CMD_READ_A_B) r_ab  <= arm_to_fpga_data;
            if (r_cmd_q == C_CMD_READ_M)   r_m   <= arm_to_fpga_data;
        end
    end

    assign fpga_to_arm_data = r_result;
    assign compute_cycles   = r_cycles;
    assign reg_exp          = r_exp;
    assign reg_ab           = r_ab;
    assign reg_m            = r_m;

endmodule
`default_nettype wire

// File: tb/tb_arm_link_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_link_responder
//  Description : Self-checking bench for arm_link_responder: vector table,
//                hand-written corner sequences and randomized commands
//                checked against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_arm_link_responder;

    localparam int DW    = 1024;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      arm_to_fpga_cmd;
    logic             arm_to_fpga_cmd_valid;
    logic             fpga_to_arm_done;
    logic             fpga_to_arm_done_read;
    logic             arm_to_fpga_data_valid;
    logic             arm_to_fpga_data_ready;
    logic [DW-1:0]    arm_to_fpga_data;
    logic             fpga_to_arm_data_valid;
    logic             fpga_to_arm_data_ready;
    logic [DW-1:0]    fpga_to_arm_data;
    logic             core_start_exp;
    logic             core_start_mont;
    logic             core_done;
    logic [DW-1:0]    core_result;
    logic [DW-1:0]    reg_exp;
    logic [DW-1:0]    reg_ab;
    logic [DW-1:0]    reg_m;
    logic [CNT_W-1:0] compute_cycles;
    logic [3:0]       leds;

    arm_link_responder #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .arm_to_fpga_cmd        (arm_to_fpga_cmd),
        .arm_to_fpga_cmd_valid  (arm_to_fpga_cmd_valid),
        .fpga_to_arm_done       (fpga_to_arm_done),
        .fpga_to_arm_done_read  (fpga_to_arm_done_read),
        .arm_to_fpga_data_valid (arm_to_fpga_data_valid),
        .arm_to_fpga_data_ready (arm_to_fpga_data_ready),
        .arm_to_fpga_data       (arm_to_fpga_data),
        .fpga_to_arm_data_valid (fpga_to_arm_data_valid),
        .fpga_to_arm_data_ready (fpga_to_arm_data_ready),
        .fpga_to_arm_data       (fpga_to_arm_data),
        .core_start_exp         (core_start_exp),
        .core_start_mont        (core_start_mont),
        .core_done              (core_done),
        .core_result            (core_result),
        .reg_exp                (reg_exp),
        .reg_ab                 (reg_ab),
        .reg_m                  (reg_m),
        .compute_cycles         (compute_cycles),
        .leds                   (leds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int n_se     = 0;
    int n_sm     = 0;

    // Transaction-level model of the link's visible state
    logic [DW-1:0] m_exp, m_ab, m_m, m_result;
    int            m_cycles;

    // Start-pulse tally, sampled on the rising edge before the state moves
    always @(posedge clk) begin
        if (core_start_exp)  n_se <= n_se + 1;
        if (core_start_mont) n_sm <= n_sm + 1;
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        logic [127:0] a_lo, e_lo;
        n_checks++;
        if (act !== exp) begin
            n_err++;
            a_lo = act[127:0];
            e_lo = exp[127:0];
            $display("FAIL %s: got %h expected %h (low 128 bits)", name, a_lo, e_lo);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [3:0] model_leds(input logic [31:0] c);
        if (c <= 2)       return 4'b0010;
        else if (c <= 4)  return 4'b0100;
        else if (c == 5)  return 4'b1000;
        else              return 4'b1111;
    endfunction

    task automatic model_reset();
        m_exp = '0; m_ab = '0; m_m = '0; m_result = '0; m_cycles = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_reg_exp"}, reg_exp, m_exp);
        chk({tag, "_reg_ab"},  reg_ab,  m_ab);
        chk({tag, "_reg_m"},   reg_m,   m_m);
        chk({tag, "_cycles"},  DW'(compute_cycles), DW'(m_cycles));
    endtask

    // One full command transaction from IDLE back to IDLE, driven at falling edges
    task automatic run_cmd(input logic [31:0] cmd, input logic [DW-1:0] data,
                           input int delay, input logic [DW-1:0] res,
                           input int txwait, input int hold, input bit abuse,
                           input logic [3:0] el, output logic [DW-1:0] tx_data);
        int se0, sm0;
        tx_data = 'x;
        @(negedge clk);
        se0 = n_se; sm0 = n_sm;
        chk("idle_leds", DW'(leds), DW'(4'b0001));
        arm_to_fpga_cmd        = cmd;
        arm_to_fpga_cmd_valid  = 1'b1;
        fpga_to_arm_data_ready = (txwait == 0);
        @(negedge clk);
        arm_to_fpga_cmd_valid = 1'b0;
        arm_to_fpga_cmd       = $urandom;
        chk("state_leds", DW'(leds), DW'(el));
        if (cmd <= 2) begin
            chk("rx_ready", DW'(arm_to_fpga_data_ready), DW'(1'b1));
            arm_to_fpga_data_valid = 1'b1;
            arm_to_fpga_data       = data;
            @(negedge clk);
            chk("rx_ready_drop", DW'(arm_to_fpga_data_ready), DW'(1'b0));
            chk("rx_done", DW'(fpga_to_arm_done), DW'(1'b1));
            for (int k = 1; k < hold; k++) begin
                arm_to_fpga_data = rand_word();
                @(negedge clk);
                chk("rx_hold_done", DW'(fpga_to_arm_done), DW'(1'b1));
            end
            arm_to_fpga_data_valid = 1'b0;
            if (cmd == 0) m_exp = data;
            if (cmd == 1) m_ab  = data;
            if (cmd == 2) m_m   = data;
        end else if (cmd <= 4) begin
            for (int k = 0; k <= delay; k++) begin
                if (k > 0) @(negedge clk);
                chk("cmp_start_exp",  DW'(core_start_exp),  DW'(k == 0 && cmd == 3));
                chk("cmp_start_mont", DW'(core_start_mont), DW'(k == 0 && cmd == 4));
                arm_to_fpga_cmd_valid  = abuse && (k == 2);
                arm_to_fpga_data_valid = abuse && (k == 2);
                arm_to_fpga_cmd        = 32'd0;
                if (k == delay) begin
                    core_done   = 1'b1;
                    core_result = res;
                end
            end
            @(negedge clk);
            core_done              = 1'b0;
            arm_to_fpga_cmd_valid  = 1'b0;
            arm_to_fpga_data_valid = 1'b0;
            core_result            = rand_word();
            chk("cmp_done", DW'(fpga_to_arm_done), DW'(1'b1));
            m_result = res;
            m_cycles = delay;
        end else if (cmd == 5) begin
            chk("tx_valid", DW'(fpga_to_arm_data_valid), DW'(1'b1));
            tx_data = fpga_to_arm_data;
            chk("tx_data", fpga_to_arm_data, m_result);
            if (txwait > 0) begin
                for (int k = 1; k < txwait; k++) begin
                    @(negedge clk);
                    chk("tx_wait_valid", DW'(fpga_to_arm_data_valid), DW'(1'b1));
                    chk("tx_wait_done",  DW'(fpga_to_arm_done), DW'(1'b0));
                end
                fpga_to_arm_data_ready = 1'b1;
            end
            @(negedge clk);
            fpga_to_arm_data_ready = 1'b0;
            chk("tx_done", DW'(fpga_to_arm_done), DW'(1'b1));
        end else begin
            chk("nop_done", DW'(fpga_to_arm_done), DW'(1'b1));
        end
        // ARM acknowledges after a short random delay; done must hold meanwhile
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
            @(negedge clk);
            chk("done_hold", DW'(fpga_to_arm_done), DW'(1'b1));
        end
        fpga_to_arm_done_read = 1'b1;
        @(negedge clk);
        fpga_to_arm_done_read = 1'b0;
        chk("ack_done_low", DW'(fpga_to_arm_done), DW'(1'b0));
        chk("ack_leds", DW'(leds), DW'(4'b0001));
        check_regs("post");
        chk("start_exp_count",  DW'(n_se - se0), DW'(cmd == 3));
        chk("start_mont_count", DW'(n_sm - sm0), DW'(cmd == 4));
    endtask

    typedef struct {
        logic [31:0]   cmd;
        logic [DW-1:0] data;
        int            delay;
        logic [DW-1:0] res;
        int            txwait;
        int            hold;
        bit            abuse;
        logic [3:0]    exp_leds;
        logic [DW-1:0] exp_val;
    } vec_t;

    vec_t          vecs[9];
    logic [DW-1:0] d1, d2, d3, txd, sel, any_out;

    initial begin
        reset = 1'b1;
        arm_to_fpga_cmd = '0; arm_to_fpga_cmd_valid = 1'b0; fpga_to_arm_done_read = 1'b0;
        arm_to_fpga_data_valid = 1'b0; arm_to_fpga_data = '0; fpga_to_arm_data_ready = 1'b0;
        core_done = 1'b0; core_result = '0;
        model_reset();

        // Reset hold with busy random inputs
        for (int i = 0; i < 3; i++) begin
            arm_to_fpga_cmd = $urandom_range(0, 7); arm_to_fpga_cmd_valid = 1'b1;
            arm_to_fpga_data_valid = 1'b1; arm_to_fpga_data = rand_word();
            core_done = 1'b1; core_result = rand_word();
            fpga_to_arm_done_read = $urandom_range(0, 1); fpga_to_arm_data_ready = $urandom_range(0, 1);
            @(negedge clk);
            any_out = DW'(fpga_to_arm_done | arm_to_fpga_data_ready | fpga_to_arm_data_valid |
                          core_start_exp | core_start_mont | (|fpga_to_arm_data) | (|reg_exp) |
                          (|reg_ab) | (|reg_m) | (|compute_cycles));
            chk("reset_outputs_zero", any_out, '0);
            chk("reset_leds", DW'(leds), DW'(4'b0001));
        end
        arm_to_fpga_cmd_valid = 1'b0; arm_to_fpga_data_valid = 1'b0; core_done = 1'b0;
        fpga_to_arm_done_read = 1'b0; fpga_to_arm_data_ready = 1'b0;
        reset = 1'b0;

        // WRITE straight after reset returns zero
        run_cmd(32'd5, '0, 0, '0, 0, 1, 1'b0, 4'b1000, txd);
        chk("write_after_reset", txd, '0);

        // Reset during COMPUTE: no done, no result capture afterwards
        @(negedge clk);
        arm_to_fpga_cmd = 32'd4; arm_to_fpga_cmd_valid = 1'b1;
        @(negedge clk);
        arm_to_fpga_cmd_valid = 1'b0;
        chk("midreset_in_compute", DW'(leds), DW'(4'b0100));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        core_done = 1'b1; core_result = DW'(32'h999);
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midreset_done", DW'(fpga_to_arm_done), DW'(1'b0));
            chk("midreset_leds", DW'(leds), DW'(4'b0001));
            chk("midreset_start", DW'(core_start_exp | core_start_mont), DW'(1'b0));
            @(negedge clk);
        end
        chk("midreset_result", fpga_to_arm_data, '0);
        model_reset();

        // Directed vector table
        d1 = rand_word(); d1[DW-1 -: 32] = 32'h12887b21; d1[19:0] = 20'ha118d;
        d2 = rand_word();
        d3 = rand_word();
        vecs[0] = '{32'd1, d1, 0, '0, 0, 1, 1'b0, 4'b0010, d1};
        vecs[1] = '{32'd2, d2, 0, '0, 0, 5, 1'b0, 4'b0010, d2};
        vecs[2] = '{32'd0, d3, 0, '0, 0, 1, 1'b0, 4'b0010, d3};
        vecs[3] = '{32'd4, '0, 37, DW'(16'hABCD), 0, 1, 1'b0, 4'b0100, DW'(37)};
        vecs[4] = '{32'd5, '0, 0, '0, 0, 1, 1'b0, 4'b1000, DW'(16'hABCD)};
        vecs[5] = '{32'd7, rand_word(), 0, '0, 0, 1, 1'b0, 4'b1111, d1};
        vecs[6] = '{32'd3, '0, 0, d2, 0, 1, 1'b0, 4'b0100, DW'(0)};
        vecs[7] = '{32'd5, '0, 0, '0, 2, 1, 1'b0, 4'b1000, d2};
        vecs[8] = '{32'd4, '0, 6, DW'(8'h77), 0, 1, 1'b1, 4'b0100, DW'(6)};
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].cmd, vecs[i].data, vecs[i].delay, vecs[i].res, vecs[i].txwait,
                    vecs[i].hold, vecs[i].abuse, vecs[i].exp_leds, txd);
            case (vecs[i].cmd)
                32'd0:        sel = reg_exp;
                32'd1:        sel = reg_ab;
                32'd2:        sel = reg_m;
                32'd3, 32'd4: sel = DW'(compute_cycles);
                32'd5:        sel = txd;
                default:      sel = reg_ab;
            endcase
            chk($sformatf("vec%0d_value", i), sel, vecs[i].exp_val);
        end

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] c;
            int          dl;
            c  = $urandom_range(0, 7);
            dl = $urandom_range(0, 12);
            run_cmd(c, rand_word(), dl, rand_word(), $urandom_range(0, 2),
                    $urandom_range(1, 3), (dl >= 4) && ($urandom_range(0, 1) == 1),
                    model_leds(c), txd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arm_link_responder.md
Name: arm_link_responder

Overview:
- FPGA-side endpoint of the ARM↔FPGA command/data link; sits between the ARM-facing ports and the Montgomery/exponentiation cores.
- Decodes 32-bit commands and accepts operand words into operand registers.
- Starts the selected core, captures its result, returns the result on the outbound data channel, and signals completion via the done/done_read handshake.

Parameters:
- DW, 1024, operand/result data width in bits
- CNT_W, 32, width of the compute-cycle counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- arm_to_fpga_cmd  in  32  command code
- arm_to_fpga_cmd_valid  in  1  command strobe, sampled only in IDLE
- fpga_to_arm_done  out  1  command completed, held until acknowledged
- fpga_to_arm_done_read  in  1  ARM acknowledge of done
- arm_to_fpga_data_valid  in  1  inbound data valid
- arm_to_fpga_data_ready  out  1  inbound data ready
- arm_to_fpga_data  in  DW  inbound operand
- fpga_to_arm_data_valid  out  1  outbound data valid
- fpga_to_arm_data_ready  in  1  outbound data ready
- fpga_to_arm_data  out  DW  outbound result (result register)
- core_start_exp  out  1  one-cycle start pulse, exponentiation core
- core_start_mont  out  1  one-cycle start pulse, Montgomery core
- core_done  in  1  core finished; core_result valid this cycle
- core_result  in  DW  core output
- reg_exp / reg_ab / reg_m  out  DW each  operand registers driven to the cores
- compute_cycles  out  CNT_W  cycles of the last compute, saturating
- leds  out  4  one-hot state indicator

Behaviour:
- Command codes: 0 READ_EXP, 1 READ_A_B_MONT, 2 READ_M_MONT, 3 COMPUTE_EXP, 4 COMPUTE_MONT, 5 WRITE. Any other code is a no-op that goes straight to DONE.
- Reset (synchronous): state=IDLE, all outputs 0, operand/result registers 0, compute_cycles 0. Reset asserted mid-operation aborts immediately; no start pulse or done is emitted afterwards.
- FSM states are IDLE, RX, COMPUTE, TX, DONE. leds = 0001/0010/0100/1000 for IDLE/RX/COMPUTE/TX; DONE = 1111.
- IDLE:
  - On cmd_valid, latch the command into cmd_q.
  - Codes 0–2 → RX. Codes 3–4 → COMPUTE. Code 5 → TX. Otherwise → DONE.
  - cmd_valid in any other state is ignored.
- RX:
  - arm_to_fpga_data_ready=1.
  - On the cycle data_valid&&ready are both high, write arm_to_fpga_data to reg_exp, reg_ab or reg_m (per cmd_q), deassert ready next cycle, → DONE.
  - Exactly one word is accepted per command. valid held high for extra cycles is not re-accepted.
- COMPUTE:
  - Raise core_start_exp (cmd 3) or core_start_mont (cmd 4) for exactly the first cycle in the state.
  - The cycle counter clears on entry and increments each cycle, saturating at all-ones.
  - On core_done: result ← core_result, compute_cycles ← counter, → DONE.
  - If core_done coincides with the start cycle, it is still honoured.
  - core_done outside COMPUTE is ignored.
- TX:
  - fpga_to_arm_data_valid=1 while in TX. fpga_to_arm_data always shows the result register.
  - On valid&&ready → DONE. ready asserted before entry completes the transfer in the first TX cycle.
  - WRITE before any compute returns 0.
- DONE:
  - fpga_to_arm_done=1.
  - When done_read is sampled 1, done clears next cycle and state → IDLE.
  - done_read in other states is ignored.
  - A new cmd_valid is accepted only from IDLE, i.e. at least one cycle after acknowledge.
- Latencies:
  - Command to RX/TX/COMPUTE: 1 cycle.
  - Handshake to done high: 1 cycle.
  - Acknowledge to IDLE: 1 cycle.
- Operand registers persist across commands and are overwritten only by their READ command.

Test Plan:
- Reset hold: reset=1 for 3 cycles with random cmd/data inputs → every output 0, leds=0001.
- Load path:
  - cmd 1 + data 0x12887b21…a118d → reg_ab equals the word after one handshake; done=1 until done_read; then IDLE.
  - Repeat for cmd 2 and 0 → reg_m and reg_exp are loaded; the other two registers are unchanged.
- Compute path: cmd 4 → core_start_mont is high exactly 1 cycle. A stub raises core_done with result 0xABCD after 37 cycles → compute_cycles=37, done asserted, core_start_exp never high.
- Write path: cmd 5 with fpga_to_arm_data_ready=1 → valid high, data=0xABCD, done follows. WRITE directly after reset → data 0.
- Protocol abuse:
  - cmd_valid pulsed during COMPUTE → ignored.
  - data_valid held 5 cycles in RX → only one write.
  - Unknown cmd 7 → done within 2 cycles, registers unchanged.
- Reset mid-operation: reset during COMPUTE at cycle 10, then core_done → no done asserted, state IDLE, result still 0.
